// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE MX datapath: slot scheduler FSM states and job configuration.
package redmule_pkg;

  localparam int unsigned MXS_DATA_W       = 256;
  localparam int unsigned MXS_EXP_VECTOR_W = 32;
  localparam int unsigned MXS_CNT_W        = 16;

  typedef enum logic [1:0] {
    MXS_IDLE  = 2'd0,
    MXS_ISSUE = 2'd1,
    MXS_GAP   = 2'd2,
    MXS_DRAIN = 2'd3
  } mx_sched_state_e;

  typedef struct packed {
    logic [MXS_CNT_W-1:0] x_reuse;
    logic [MXS_CNT_W-1:0] num_x;
  } mx_sched_cfg_t;

  // A job with no X slots or no W reuse produces no pairs at all.
  function automatic logic cfg_is_empty(input mx_sched_cfg_t cfg);
    return (cfg.x_reuse == {MXS_CNT_W{1'b0}}) || (cfg.num_x == {MXS_CNT_W{1'b0}});
  endfunction

endpackage

// File: rtl/redmule_mx_slot_scheduler.sv
// Pairs each X slot with R consecutive W slots, pops the slot buffer heads and presents
// every (X,W) pair to the MX decode stage through one valid/ready output register.
module redmule_mx_slot_scheduler
  import redmule_pkg::*;
#(
  parameter int unsigned MX_DATA_W       = MXS_DATA_W,
  parameter int unsigned MX_EXP_VECTOR_W = MXS_EXP_VECTOR_W,
  parameter int unsigned CNT_W           = MXS_CNT_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [CNT_W-1:0]           cfg_x_reuse_i,
  input  logic [CNT_W-1:0]           cfg_num_x_i,
  output logic                       busy_o,
  output logic                       done_o,
  input  logic                       x_slot_valid_i,
  input  logic                       x_slot_exp_valid_i,
  input  logic [MX_DATA_W-1:0]       x_slot_data_i,
  input  logic [7:0]                 x_slot_exp_i,
  input  logic                       w_slot_valid_i,
  input  logic                       w_slot_exp_valid_i,
  input  logic [MX_DATA_W-1:0]       w_slot_data_i,
  input  logic [MX_EXP_VECTOR_W-1:0] w_slot_exp_i,
  output logic                       consume_x_slot_o,
  output logic                       consume_w_slot_o,
  output logic                       pair_valid_o,
  input  logic                       pair_ready_i,
  output logic [MX_DATA_W-1:0]       pair_x_data_o,
  output logic [7:0]                 pair_x_exp_o,
  output logic [MX_DATA_W-1:0]       pair_w_data_o,
  output logic [MX_EXP_VECTOR_W-1:0] pair_w_exp_o,
  output logic                       pair_last_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  mx_sched_state_e      state;
  mx_sched_state_e      next_state;
  mx_sched_cfg_t        cfg;
  mx_sched_cfg_t        start_cfg;
  logic [CNT_W-1:0]     w_cnt;
  logic [CNT_W-1:0]     x_cnt;
  logic [MX_DATA_W-1:0] x_hold_data;
  logic [7:0]           x_hold_exp;

  logic xr;
  logic wr;
  logic oreg_free;
  logic first_use;
  logic w_wrap;
  logic x_wrap;
  logic last_pair;
  logic fire;
  logic drain_done;

  assign xr         = x_slot_valid_i & x_slot_exp_valid_i;
  assign wr         = w_slot_valid_i & w_slot_exp_valid_i;
  assign oreg_free  = ~pair_valid_o | pair_ready_i;
  assign first_use  = (w_cnt == CNT_ZERO);
  assign w_wrap     = (w_cnt == (cfg.x_reuse - CNT_ONE));
  assign x_wrap     = (x_cnt == (cfg.num_x - CNT_ONE));
  assign last_pair  = w_wrap & x_wrap;
  assign drain_done = ~pair_valid_o | pair_ready_i;

  // A soft clear in the same cycle must not pop the buffer.
  assign fire = (state == MXS_ISSUE) & ~clear_i & wr & oreg_free & (~first_use | xr);

  assign consume_w_slot_o = fire;
  assign consume_x_slot_o = fire & first_use;
  assign busy_o           = (state != MXS_IDLE);

  always_comb begin
    start_cfg         = '0;
    start_cfg.x_reuse = cfg_x_reuse_i;
    start_cfg.num_x   = cfg_num_x_i;
  end

  always_comb begin
    next_state = state;
    case (state)
      MXS_IDLE: begin
        if (start_i) begin
          next_state = cfg_is_empty(start_cfg) ? MXS_DRAIN : MXS_ISSUE;
        end else begin
          next_state = MXS_IDLE;
        end
      end
      MXS_ISSUE: begin
        if (fire) begin
          next_state = last_pair ? MXS_DRAIN : MXS_GAP;
        end else begin
          next_state = MXS_ISSUE;
        end
      end
      MXS_GAP: begin
        next_state = MXS_ISSUE;
      end
      MXS_DRAIN: begin
        if (drain_done) begin
          next_state = MXS_IDLE;
        end else begin
          next_state = MXS_DRAIN;
        end
      end
      default: begin
        next_state = MXS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= MXS_IDLE;
      cfg         <= '0;
      w_cnt       <= CNT_ZERO;
      x_cnt       <= CNT_ZERO;
      x_hold_data <= {MX_DATA_W{1'b0}};
      x_hold_exp  <= 8'h00;
      done_o      <= 1'b0;
    end else if (clear_i) begin
      state       <= MXS_IDLE;
      cfg         <= '0;
      w_cnt       <= CNT_ZERO;
      x_cnt       <= CNT_ZERO;
      x_hold_data <= {MX_DATA_W{1'b0}};
      x_hold_exp  <= 8'h00;
      done_o      <= 1'b0;
    end else begin
      state  <= next_state;
      done_o <= (state == MXS_DRAIN) & drain_done;
      if ((state == MXS_IDLE) && start_i) begin
        cfg   <= start_cfg;
        w_cnt <= CNT_ZERO;
        x_cnt <= CNT_ZERO;
      end
      if (fire) begin
        // The X head is popped on its first use, so later pairs read the held copy.
        if (first_use) begin
          x_hold_data <= x_slot_data_i;
          x_hold_exp  <= x_slot_exp_i;
        end
        if (w_wrap) begin
          w_cnt <= CNT_ZERO;
          x_cnt <= x_cnt + CNT_ONE;
        end else begin
          w_cnt <= w_cnt + CNT_ONE;
        end
      end
    end
  end

  // Output pair register: data only changes on a new fire, so it is stable while stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pair_valid_o  <= 1'b0;
      pair_x_data_o <= {MX_DATA_W{1'b0}};
      pair_x_exp_o  <= 8'h00;
      pair_w_data_o <= {MX_DATA_W{1'b0}};
      pair_w_exp_o  <= {MX_EXP_VECTOR_W{1'b0}};
      pair_last_o   <= 1'b0;
    end else if (clear_i) begin
      pair_valid_o  <= 1'b0;
      pair_x_data_o <= {MX_DATA_W{1'b0}};
      pair_x_exp_o  <= 8'h00;
      pair_w_data_o <= {MX_DATA_W{1'b0}};
      pair_w_exp_o  <= {MX_EXP_VECTOR_W{1'b0}};
      pair_last_o   <= 1'b0;
    end else if (fire) begin
      pair_valid_o  <= 1'b1;
      pair_x_data_o <= first_use ? x_slot_data_i : x_hold_data;
      pair_x_exp_o  <= first_use ? x_slot_exp_i : x_hold_exp;
      pair_w_data_o <= w_slot_data_i;
      pair_w_exp_o  <= w_slot_exp_i;
      pair_last_o   <= last_pair;
    end else if (pair_valid_o && pair_ready_i) begin
      pair_valid_o  <= 1'b0;
    end else begin
      pair_valid_o  <= pair_valid_o;
    end
  end

endmodule
